// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM/owner encodings and
// the data/address width defaults common to the memory and the CPU.
package mem_port_arbiter_pkg;

    localparam int BITS_DATA_DEF = 32;
    localparam int BITS_ADDR_DEF = 16;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    // Owner of the access currently in flight
    localparam logic OWN_F = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Saturating increment of the fetch starvation counter
    function automatic logic [3:0] starve_inc(input logic [3:0] cnt, input logic [3:0] max);
        return (cnt >= max) ? max : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port async-read memory.
// Data port has fixed priority; fetch is forced through after STARVE_MAX
// consecutive losses. One access in flight: IDLE -> GRANT -> ACK -> IDLE.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int BITS_DATA  = BITS_DATA_DEF,
    parameter int BITS_ADDR  = BITS_ADDR_DEF,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 f_req,
    input  logic [BITS_ADDR-1:0] f_addr,
    output logic                 f_ack,
    output logic [BITS_DATA-1:0] f_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [BITS_ADDR-1:0] d_addr,
    input  logic [BITS_DATA-1:0] d_wdata,
    output logic                 d_ack,
    output logic [BITS_DATA-1:0] d_rdata,
    output logic [BITS_ADDR-1:0] mem_address,
    output logic [BITS_DATA-1:0] mem_data_in,
    output logic                 mem_write,
    input  logic [BITS_DATA-1:0] mem_data_out,
    output logic                 busy
);

    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    logic [1:0]           r_state;
    logic [BITS_ADDR-1:0] r_addr;
    logic [BITS_DATA-1:0] r_wdata;
    logic                 r_we;
    logic                 r_owner;
    logic [3:0]           r_starve;
    logic                 r_f_ack;
    logic                 r_d_ack;
    logic [BITS_DATA-1:0] r_f_rdata;
    logic [BITS_DATA-1:0] r_d_rdata;

    logic w_any_req;
    logic w_f_forced;
    logic w_d_wins;

    // Winner selection: D by priority unless F has lost too many times in a row
    always_comb begin
        w_any_req  = f_req | d_req;
        w_f_forced = f_req & (r_starve == LP_STARVE_MAX);
        w_d_wins   = d_req & ~w_f_forced;
    end

    // Arbitration FSM, request latch, starvation counter and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_owner   <= OWN_F;
            r_starve  <= 4'd0;
            r_f_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_f_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Counter only moves on an arbitration edge; any cycle
                    // without a pending fetch breaks the losing streak.
                    if (f_req && w_d_wins)
                        r_starve <= starve_inc(r_starve, LP_STARVE_MAX);
                    else
                        r_starve <= 4'd0;
                    if (w_any_req) begin
                        if (w_d_wins) begin
                            r_addr  <= d_addr;
                            r_wdata <= d_wdata;
                            r_we    <= d_we;
                            r_owner <= OWN_D;
                        end else begin
                            r_addr  <= f_addr;
                            r_wdata <= '0;
                            r_we    <= 1'b0;
                            r_owner <= OWN_F;
                        end
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Memory read is async, so its output is valid by this edge
                    if (r_owner == OWN_D) begin
                        r_d_ack <= 1'b1;
                        if (!r_we)
                            r_d_rdata <= mem_data_out;
                    end else begin
                        r_f_ack   <= 1'b1;
                        r_f_rdata <= mem_data_out;
                    end
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    // Still-high requests are ignored here to avoid a re-grant
                    r_f_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Write strobe decoded from state so a reset in GRANT drops it at once
    always_comb begin
        mem_write   = (r_state == ST_GRANT) & r_we;
        mem_address = r_addr;
        mem_data_in = r_wdata;
        busy        = (r_state == ST_GRANT) | (r_state == ST_ACK);
        f_ack       = r_f_ack;
        d_ack       = r_d_ack;
        f_rdata     = r_f_rdata;
        d_rdata     = r_d_rdata;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 32-bit x 64Ki-word memory (async read, negedge-clk write) between two requesters: instruction fetch (port F) and data load/store (port D).
- Sits between the CPU control unit and the memory instance and owns that memory's address, data_in and write pins.
- Fixed priority to D, with a starvation guard that forces an F grant after a bounded number of consecutive losses.
- Request/acknowledge handshake; one access in flight at a time.

Parameters:
- BITS_DATA, 32, data word width.
- BITS_ADDR, 16, word address width.
- STARVE_MAX, 3, consecutive arbitration losses by F before F is forced to win (1..15).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch request; held high with f_addr stable until f_ack.
- f_addr  in  BITS_ADDR  fetch word address.
- f_ack  out  1  one-cycle pulse; f_rdata valid while high.
- f_rdata  out  BITS_DATA  fetched word (registered).
- d_req  in  1  data request; held high with d_addr/d_wdata/d_we stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  BITS_ADDR  data word address.
- d_wdata  in  BITS_DATA  store data.
- d_ack  out  1  one-cycle pulse; load data valid / store committed.
- d_rdata  out  BITS_DATA  loaded word (registered).
- mem_address  out  BITS_ADDR  to memory address.
- mem_data_in  out  BITS_DATA  to memory data_in.
- mem_write  out  1  to memory write.
- mem_data_out  in  BITS_DATA  from memory data_out (async read).
- busy  out  1  high in GRANT or ACK.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; f_ack=d_ack=0; f_rdata=d_rdata=0; latched addr/wdata/we/owner=0, so mem_address=0 and mem_data_in=0; mem_write=0; starve_cnt=0; busy=0.
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise select the winner:
    - D wins if d_req=1, unless f_req=1 and starve_cnt==STARVE_MAX.
    - Else F wins if f_req=1.
  - At the posedge, latch the winner's addr, wdata and we (F forces we=0) plus owner, then go to GRANT.
- starve_cnt update, at the IDLE arbitration edge only:
  - D wins while f_req=1: starve_cnt+1, saturating at STARVE_MAX.
  - F wins: starve_cnt cleared to 0.
  - f_req=0: starve_cnt cleared to 0.
- GRANT, exactly one cycle:
  - mem_address and mem_data_in driven from the latch.
  - mem_write = latched we, combinational from state, so the memory commits on the negedge inside this cycle.
  - At the posedge, capture mem_data_out into the owner's rdata register, set the owner's ack, go to ACK.
  - A store leaves the owner's rdata unchanged.
- ACK, exactly one cycle:
  - Owner's ack=1; mem_write=0.
  - Requests are ignored, so the requester's still-high req is not re-granted.
  - Next state: IDLE; ack clears.
- Latency: req high at posedge N in IDLE, then GRANT from N to N+1, ack high from N+1 to N+2. Sustained throughput is 1 access per 3 cycles.
- Outside GRANT, mem_write=0 and mem_address/mem_data_in hold the last latched values.
- Simultaneous f_req and d_req: resolved by the priority rule above. The loser's req stays high and is evaluated at the next IDLE.
- A requester dropping req before its ack is a protocol violation. The latched access still completes and the ack still pulses.
- Reset during GRANT deasserts mem_write immediately. A store whose negedge has not yet occurred is therefore not committed; no ack is issued.
- f_rdata/d_rdata hold their value until that port's next load completes.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, GRANT=2'd1, ACK=2'd2), owner encoding (OWN_F=1'b0, OWN_D=1'b1), BITS_DATA/BITS_ADDR defaults shared with the memory and CPU.
- No sub-module: a single module holding the FSM, request latch, starvation counter and response registers.

Test Plan:
- Reset: after rst_n low then high, all outputs are 0 and state is IDLE. Then f_req=1, f_addr=0x0002 with mem[2]=0x09020001 -> f_ack pulses exactly 2 cycles after the first sampling edge; f_rdata=0x09020001; mem_write never high.
- D store: d_we=1, d_addr=0x1F40, d_wdata=0x0000000C -> mem_write high only during GRANT; d_ack then pulses once. A subsequent load from 0x1F40 returns 0x0000000C in d_rdata.
- Collision: f_req and d_req both rise on the same edge -> D served first. F is granted at the next IDLE and f_ack follows d_ack by 3 cycles.
- Starvation: d_req held permanently high with f_req high and STARVE_MAX=3 -> grant order D,D,D,F,D,D,D,F. starve_cnt resets to 0 after each F grant.
- ACK-cycle hold: requester keeps req high during ACK -> no second grant in that cycle. Exactly one ack per access when req is dropped on ack.
- Reset mid-GRANT: rst_n pulled low during a store's GRANT before the negedge -> mem_write falls immediately, memory content unchanged, no d_ack, FSM in IDLE after release.
